// File: rtl/filter_pkg.sv
// Shared FIR sequencing definitions: state encoding and default filter geometry.
// The MAC datapath uses the same TAPS/MAC_LAT defaults, so they live here.
package filter_pkg;

    localparam int N_CH_DEF    = 2;
    localparam int TAPS_DEF    = 32;
    localparam int MAC_LAT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_edge.sv
// Synchronises the divider's square-wave tick and emits a one-cycle pulse per rising edge.
// Latency: 3 clk from raw rise to tick_rise; no backpressure.
module tick_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic tick_rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic rise_q;

    // The edge pulse is registered so downstream control sees a clean flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            s3_q   <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= tick;
            s2_q   <= s1_q;
            s3_q   <= s2_q;
            rise_q <= s2_q & ~s3_q;
        end
    end

    assign tick_rise = rise_q;

endmodule

// File: rtl/filter_sched.sv
// Time-shares one FIR MAC between channels: per pending channel CLR, TAPS x RUN, DRAIN, DONE.
// Latency: first mac_clr 4 clk after raw tick rise; no backpressure, late ticks flag overrun.
module filter_sched
    import filter_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int TAPS    = TAPS_DEF,
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int AW      = $clog2(TAPS),
    parameter int CW      = clog2_min1(N_CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic [N_CH-1:0] ch_valid,
    input  logic            clr_overrun,
    output logic            mac_clr,
    output logic            mac_en,
    output logic [AW-1:0]   tap_idx,
    output logic [CW-1:0]   ch_sel,
    output logic            out_valid,
    output logic [CW-1:0]   out_ch,
    output logic            busy,
    output logic            overrun
);

    localparam int DW = clog2_min1(MAC_LAT);
    localparam logic [AW-1:0] TAP_LAST   = AW'(TAPS - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

    logic tick_rise;

    tick_edge u_tick_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .tick_rise (tick_rise)
    );

    state_e            state_q, state_d;
    logic [N_CH-1:0]   pend_q, pend_d;
    logic [AW-1:0]     tap_q, tap_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic [CW-1:0]     sel_q, sel_d;
    logic              ovr_q, ovr_d;
    logic [N_CH-1:0]   sel_mask;
    logic [N_CH-1:0]   remain;

    function automatic logic [CW-1:0] lowest(input logic [N_CH-1:0] v);
        logic [CW-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) r = CW'(i);
        end
        return r;
    endfunction

    always_comb begin
        sel_mask = '0;
        for (int i = 0; i < N_CH; i++) begin
            sel_mask[i] = (sel_q == CW'(i));
        end
        remain = pend_q & ~sel_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            tap_q   <= '0;
            drain_q <= '0;
            sel_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tap_q   <= tap_d;
            drain_q <= drain_d;
            sel_q   <= sel_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        tap_d     = tap_q;
        drain_d   = drain_q;
        sel_d     = sel_q;
        ovr_d     = ovr_q;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tick_rise) begin
                    pend_d = ch_valid;
                    if (|ch_valid) begin
                        state_d = ST_CLR;
                        sel_d   = lowest(ch_valid);
                    end
                end
            end
            ST_CLR: begin
                mac_clr = 1'b1;
                tap_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                mac_en = 1'b1;
                // tap_idx parks on the last tap until the next CLR reloads it.
                if (tap_q == TAP_LAST) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    tap_d = tap_q + AW'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                pend_d    = remain;
                if (|remain) begin
                    state_d = ST_CLR;
                    sel_d   = lowest(remain);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A tick arriving mid-frame is dropped; setting outranks a simultaneous clear.
        if (clr_overrun) ovr_d = 1'b0;
        if (tick_rise && (state_q != ST_IDLE)) ovr_d = 1'b1;
    end

    assign tap_idx = tap_q;
    assign ch_sel  = sel_q;
    assign out_ch  = sel_q;
    assign busy    = (state_q != ST_IDLE);
    assign overrun = ovr_q;

endmodule

// File: doc/filter_sched.md
# filter_sched

Sequencer that time-shares one FIR multiply-accumulate datapath between audio channels. On each rising edge of the 40 kHz sample clock from the frequency divider, it captures which channels hold a new sample. It then runs each pending channel through the shared MAC in turn: clear, TAPS accumulate cycles, pipeline drain, result strobe. It sits between the sample-rate divider and the filter datapath, and flags overrun when a new sample period starts before the previous frame has finished.

## Interface
- `N_CH`, default 2: number of channels sharing the MAC.
- `TAPS`, default 32: FIR taps per channel.
- `MAC_LAT`, default 2: cycles from the last `mac_en` until the accumulator output is valid.
- `AW`, default `$clog2(TAPS)`: tap index width.
- `CW`, default `$clog2(N_CH)` (minimum 1): channel index width.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  sample-rate clock from the divider, a square wave; only its rising edge is used.
- `ch_valid`  in  N_CH  per-channel "new sample ready" flags, sampled on the detected tick edge.
- `clr_overrun`  in  1  one-cycle pulse that clears `overrun`.
- `mac_clr`  out  1  clears the accumulator for the channel on `ch_sel`.
- `mac_en`  out  1  accumulates `coef[tap_idx] * x[ch_sel][tap_idx]`.
- `tap_idx`  out  AW  coefficient and delay-line index.
- `ch_sel`  out  CW  channel currently owning the MAC.
- `out_valid`  out  1  one-cycle strobe: the accumulator holds the result for `out_ch`.
- `out_ch`  out  CW  channel of the current result.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  sticky flag: a tick edge arrived while busy.

## Operation
- **Edge detect:**
  - `tick` passes through a 2-flop synchroniser followed by one delay flop.
  - `tick_rise = s2 & ~s3`.
- **On `tick_rise` in IDLE:**
  - Latch `pend <= ch_valid`.
  - If `pend` is nonzero, go to CLR with `ch_sel` set to the lowest set bit.
  - If `ch_valid == 0`, stay in IDLE and drive no outputs.
- **States:**
  - IDLE.
  - CLR: `mac_clr=1` for 1 cycle; tap counter loads 0.
  - RUN: `mac_en=1` for TAPS cycles; `tap_idx` counts 0..TAPS-1, incrementing each cycle.
  - DRAIN: MAC_LAT cycles with `mac_en=0`.
  - DONE: `out_valid=1`, `out_ch=ch_sel` for 1 cycle; clear `pend[ch_sel]`. Go to CLR with the next-lowest pending channel, or to IDLE if none remain.
- **Arbitration:** fixed priority by index, low index first. Each channel is served exactly once per frame.
- **Overrun:**
  - A `tick_rise` while `busy` sets `overrun`. The edge is discarded and the current frame completes unchanged.
  - `clr_overrun` clears the flag. If a set and a clear occur in the same cycle, set wins.
- `ch_valid` changes between tick edges are ignored.
- `tap_idx` holds its value outside RUN. `ch_sel` holds the last served channel in IDLE.

## Timing
- **Reset values:** all outputs 0, state IDLE, `pend=0`, synchroniser flops 0. Reset asserted mid-frame aborts the frame immediately; no `out_valid` is produced for it.
- **Latency:**
  - Raw `tick` rise to `tick_rise`: 3 clk.
  - `tick_rise` to first `mac_clr`: 1 clk.
- **Per-channel slot:** `1 + TAPS + MAC_LAT + 1` cycles, with DONE directly followed by the next channel's CLR. There are no gap cycles.
- **Frame length:** `k * (TAPS + MAC_LAT + 2)` for k pending channels. The integrator must keep `N_CH * (TAPS + MAC_LAT + 2) + 4` below the tick period (1250 clk at 40 kHz). The default parameters give 72 cycles.
- `mac_clr` and `mac_en` are never high in the same cycle.
- `out_valid` is never high in consecutive cycles.

## Structure
- **Shared filter package/header:**
  - State encoding: IDLE=0, CLR=1, RUN=2, DRAIN=3, DONE=4.
  - Default `TAPS` and `MAC_LAT` constants, which the MAC datapath also uses.
- **Sub-module `tick_edge`:** synchroniser plus rising-edge detector, outputting a one-cycle `tick_rise`. It is reused wherever the divider output crosses into control logic.
- The remainder is a single FSM plus the tap counter, the `pend` register and the overrun flag.

## Test plan
All scenarios use `N_CH=2`, `TAPS=4`, `MAC_LAT=2`, and a 40 kHz `tick` derived from clk/1250.
- **Both channels:** tick rise with `ch_valid=2'b11`.
  - `mac_clr` 4 clk after the raw rise.
  - `mac_en` for 4 cycles with `tap_idx` 0,1,2,3.
  - `out_valid` with `out_ch=0` 7 cycles after `mac_clr`.
  - Channel 1's `mac_clr` on the next cycle; second `out_valid` 8 cycles after the first.
  - `busy` high for 16 cycles.
- **Single channel:** `ch_valid=2'b10` gives one slot with `ch_sel=1` and exactly one `out_valid` (`out_ch=1`). `ch_valid=2'b00` gives no output and `busy` stays 0.
- **Overrun:** force a second tick rise 10 cycles into a frame.
  - `overrun=1` one cycle later.
  - The frame still emits 2 `out_valid`.
  - No restart occurs.
  - Pulsing `clr_overrun` clears the flag; a set and clear in the same cycle leaves it at 1.
- **Reset mid-RUN:** assert `rst_n=0` mid-RUN. All outputs are 0 asynchronously, with no `out_valid`. After release, the next tick runs a normal frame.
- **Late `ch_valid`:** `ch_valid` toggles between ticks and mid-frame. Only the value at `tick_rise` is served.
